// File: rtl/odo_work_feeder.sv
// Work feeder for odo_keccak: latches a header template and nonce range, then issues one header per slot.
// Optional macro ODO_NONCE_BSWAP_EN inserts the nonce byte-swapped (little-endian header layout).
module odo_work_feeder #(
  parameter int ISSUE_INTERVAL = 1,
  parameter int NONCE_LSB      = 608
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [639:0] work_data,
  input  logic         work_load,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic         run,
  output logic [639:0] out_data,
  output logic         out_valid,
  output logic [31:0]  cur_nonce,
  output logic         busy,
  output logic         exhausted
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

  // GAP lasts ISSUE_INTERVAL-1 cycles; the count is reloaded as N-2 because GAP exits on 0.
  localparam logic [15:0]  GAP_INIT   = 16'((ISSUE_INTERVAL > 1) ? ISSUE_INTERVAL - 2 : 0);
  localparam logic [639:0] NONCE_MASK = 640'(32'hFFFF_FFFF) << NONCE_LSB;

  state_t         state_q, state_d;
  logic [639:0]   tmpl_q, tmpl_d;
  logic [31:0]    ctr_q, ctr_d;
  logic [31:0]    end_q, end_d;
  logic [15:0]    gap_q, gap_d;
  logic [639:0]   out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic [31:0]    cur_nonce_q, cur_nonce_d;
  logic           busy_q, busy_d;
  logic           exhausted_q, exhausted_d;
  logic [31:0]    nonce_ins;

`ifdef ODO_NONCE_BSWAP_EN
  assign nonce_ins = {ctr_q[7:0], ctr_q[15:8], ctr_q[23:16], ctr_q[31:24]};
`else
  assign nonce_ins = ctr_q;
`endif

  always_comb begin
    state_d     = state_q;
    tmpl_d      = tmpl_q;
    ctr_d       = ctr_q;
    end_d       = end_q;
    gap_d       = gap_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    cur_nonce_d = cur_nonce_q;
    busy_d      = busy_q;
    exhausted_d = exhausted_q;
    if (work_load) begin
      // A load aborts whatever is in flight, including a pending issue or gap.
      state_d     = ISSUE;
      tmpl_d      = work_data;
      ctr_d       = nonce_start;
      end_d       = nonce_end;
      gap_d       = '0;
      busy_d      = 1'b1;
      exhausted_d = 1'b0;
    end else begin
      case (state_q)
        ISSUE: begin
          if (run) begin
            out_valid_d = 1'b1;
            out_data_d  = (tmpl_q & ~NONCE_MASK) | (640'(nonce_ins) << NONCE_LSB);
            cur_nonce_d = ctr_q;
            if (ctr_q == end_q) begin
              state_d     = DONE;
              busy_d      = 1'b0;
              exhausted_d = 1'b1;
            end else begin
              ctr_d = ctr_q + 32'd1;
              if (ISSUE_INTERVAL > 1) begin
                state_d = GAP;
                gap_d   = GAP_INIT;
              end
            end
          end
        end
        GAP: begin
          if (gap_q == '0) state_d = ISSUE;
          else             gap_d   = gap_q - 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tmpl_q      <= '0;
      ctr_q       <= '0;
      end_q       <= '0;
      gap_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cur_nonce_q <= '0;
      busy_q      <= 1'b0;
      exhausted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmpl_q      <= tmpl_d;
      ctr_q       <= ctr_d;
      end_q       <= end_d;
      gap_q       <= gap_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      cur_nonce_q <= cur_nonce_d;
      busy_q      <= busy_d;
      exhausted_q <= exhausted_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign cur_nonce = cur_nonce_q;
  assign busy      = busy_q;
  assign exhausted = exhausted_q;

endmodule

// File: tb/tb_odo_work_feeder.sv
// Bench for odo_work_feeder: two instances (interval 1 and 4) checked every cycle against an issue-schedule model.
module tb_odo_work_feeder;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [639:0] work_data = '0;
  logic         work_load = 1'b0;
  logic [31:0]  nonce_start = '0, nonce_end = '0;
  logic         run = 1'b0;

  logic [639:0] a_data, b_data;
  logic         a_valid, b_valid, a_busy, b_busy, a_exh, b_exh;
  logic [31:0]  a_nonce, b_nonce;

  always #5 clk = ~clk;

  odo_work_feeder #(.ISSUE_INTERVAL(1)) dut1 (
    .clk(clk), .reset(reset), .work_data(work_data), .work_load(work_load),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .run(run),
    .out_data(a_data), .out_valid(a_valid), .cur_nonce(a_nonce), .busy(a_busy), .exhausted(a_exh));

  odo_work_feeder #(.ISSUE_INTERVAL(4)) dut4 (
    .clk(clk), .reset(reset), .work_data(work_data), .work_load(work_load),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .run(run),
    .out_data(b_data), .out_valid(b_valid), .cur_nonce(b_nonce), .busy(b_busy), .exhausted(b_exh));

  int checks = 0;
  int failures = 0;
  logic [31:0] q1[$];
  logic [31:0] q4[$];

`ifdef ODO_NONCE_BSWAP_EN
  localparam logic [31:0] PLACE_EXP = 32'h7856_3412;
`else
  localparam logic [31:0] PLACE_EXP = 32'h1234_5678;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] field(input logic [31:0] n);
`ifdef ODO_NONCE_BSWAP_EN
    return {n[7:0], n[15:8], n[23:16], n[31:24]};
`else
    return n;
`endif
  endfunction

  // Model: a loaded range issues at the first edge with run high that is at least
  // IV cycles after the previous issue (1 cycle after the load).
  int          cyc = 0;
  int          iv[2] = '{1, 4};
  logic [639:0] m_tmpl[2], m_data[2];
  logic [31:0] m_ctr[2], m_end[2], m_nonce[2];
  logic        m_valid[2], m_busy[2], m_exh[2];
  int          m_elig[2];

  task automatic model_step();
    cyc++;
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0;
      if (reset) begin
        m_data[k] = '0; m_nonce[k] = '0; m_busy[k] = 1'b0; m_exh[k] = 1'b0;
      end else if (work_load) begin
        m_tmpl[k] = work_data; m_ctr[k] = nonce_start; m_end[k] = nonce_end;
        m_busy[k] = 1'b1; m_exh[k] = 1'b0; m_elig[k] = cyc + 1;
      end else if (m_busy[k] && run && cyc >= m_elig[k]) begin
        m_valid[k] = 1'b1;
        m_data[k]  = m_tmpl[k];
        m_data[k][639:608] = field(m_ctr[k]);
        m_nonce[k] = m_ctr[k];
        if (m_ctr[k] == m_end[k]) begin
          m_busy[k] = 1'b0; m_exh[k] = 1'b1;
        end else begin
          m_ctr[k] = m_ctr[k] + 32'd1;
        end
        m_elig[k] = cyc + iv[k];
      end
    end
  endtask

  task automatic cmp(input int k, input logic v, input logic [639:0] d, input logic [31:0] n,
                     input logic b, input logic e);
    checks++;
    if (v !== m_valid[k] || d !== m_data[k] || n !== m_nonce[k] || b !== m_busy[k] || e !== m_exh[k]) begin
      failures++;
      $display("FAIL model k=%0d cyc=%0d valid=%b/%b busy=%b/%b exh=%b/%b nonce=%h/%h data_diff=%h",
               k, cyc, v, m_valid[k], b, m_busy[k], e, m_exh[k], n, m_nonce[k], d ^ m_data[k]);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #1;
    cmp(0, a_valid, a_data, a_nonce, a_busy, a_exh);
    cmp(1, b_valid, b_data, b_nonce, b_busy, b_exh);
    if (a_valid === 1'b1) q1.push_back(a_nonce);
    if (b_valid === 1'b1) q4.push_back(b_nonce);
  end

  task automatic chk_seq(input string name, input logic [31:0] q[$], input logic [31:0] first, input int n);
    logic [31:0] e;
    chk({name, "_cnt"}, 64'(q.size()), 64'(n));
    for (int i = 0; i < n && i < q.size(); i++) begin
      e = first + 32'(i);
      chk(name, 64'(q[i]), 64'(e));
    end
  endtask

  // Drive the load at a negedge; the load edge itself must carry no strobe.
  task automatic load(input logic [639:0] d, input logic [31:0] s, input logic [31:0] e);
    work_data = d; nonce_start = s; nonce_end = e; work_load = 1'b1;
    q1.delete(); q4.delete();
    @(posedge clk); #1;
    chk("load_nostrobe", 64'({a_valid, b_valid}), 64'(0));
    chk("load_busy", 64'({a_busy, b_busy}), 64'(2'b11));
    chk("load_exh_clr", 64'({a_exh, b_exh}), 64'(0));
    @(negedge clk);
    work_load = 1'b0;
  endtask

  function automatic logic [639:0] rand_tmpl();
    logic [639:0] t;
    for (int i = 0; i < 20; i++) t[i*32 +: 32] = $urandom;
    return t;
  endfunction

  logic [639:0] t3, exp_d;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(a_valid), 64'(0));
    chk("rst_busy_exh", 64'({a_busy, a_exh, b_busy, b_exh}), 64'(0));
    chk("rst_nonce", 64'(a_nonce), 64'(0));
    chk("rst_data", 64'(|{a_data, b_data}), 64'(0));
    reset = 1'b0; run = 1'b1;

    load(rand_tmpl(), 32'h10, 32'h13);
    repeat (20) @(negedge clk);
    chk_seq("basic1", q1, 32'h10, 4);
    chk_seq("basic4", q4, 32'h10, 4);
    chk("basic_done", 64'({a_busy, a_exh}), 64'(2'b01));

    load(rand_tmpl(), 32'hAB, 32'hAB);
    repeat (20) @(negedge clk);
    chk_seq("single4", q4, 32'hAB, 1);
    chk("single4_exh", 64'({b_busy, b_exh}), 64'(2'b01));

    load(rand_tmpl(), 32'hFFFF_FFFE, 32'h1);
    repeat (20) @(negedge clk);
    chk_seq("wrap1", q1, 32'hFFFF_FFFE, 4);
    chk_seq("wrap4", q4, 32'hFFFF_FFFE, 4);

    load(rand_tmpl(), 32'h50, 32'h60);
    repeat (2) @(negedge clk);
    run = 1'b0;
    chk("pause_pre", 64'(q1.size()), 64'(2));
    repeat (5) @(negedge clk);
    chk("pause_hold", 64'(q1.size()), 64'(2));
    run = 1'b1;
    repeat (80) @(negedge clk);
    chk_seq("pause1", q1, 32'h50, 17);
    chk_seq("pause4", q4, 32'h50, 17);

    load(rand_tmpl(), 32'h200, 32'h201);
    repeat (3) @(negedge clk);
    chk("reload_pre_exh", 64'({a_exh, b_exh}), 64'(2'b10));
    t3 = rand_tmpl();
    load(t3, 32'h100, 32'h1FF);
    repeat (2) @(negedge clk);
    chk("reload_cnt", 64'({q1.size() > 0, q4.size() > 0}), 64'(2'b11));
    if (q1.size() > 0) chk("reload_nonce1", 64'(q1[0]), 64'(32'h100));
    if (q4.size() > 0) chk("reload_nonce4", 64'(q4[0]), 64'(32'h100));
    exp_d = t3;
    exp_d[639:608] = field(32'h100);
    chk("reload_tmpl_lo", 64'(b_data[607:0] ^ exp_d[607:0]), 64'(0));

    load({640{1'b1}}, 32'h1234_5678, 32'h1234_5678);
    @(negedge clk);
    chk("place_field", 64'(a_data[639:608]), 64'(PLACE_EXP));
    chk("place_rest", 64'(&a_data[607:0]), 64'(1));
    chk("place_nonce", 64'(a_nonce), 64'(32'h1234_5678));

    reset = 1'b1; work_load = 1'b1;
    @(negedge clk);
    chk("rst_over_load", 64'({a_busy, a_exh, a_valid, b_busy}), 64'(0));
    reset = 1'b0; work_load = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
